// File: rtl/instruction_feeder.sv
// ----------------------------------------------------------------------------
// instruction_feeder
//
// Holds a small program memory and plays it out, one 16-bit instruction at a
// time, onto a processor instruction input. Each instruction is held for
// DWELL clock cycles. After the last instruction the block parks in DONE with
// a sticky done flag.
//
// Parameters
//   DEPTH   program memory depth in words (power of two, 2..256)
//   DWELL   cycles each instruction is held on iin (1..15)
//
// Ports
//   clock    in   system clock, rising edge
//   resetn   in   synchronous active-low reset
//   wr_en    in   program-memory write strobe (honoured in IDLE/DONE only)
//   wr_addr  in   program-memory write address
//   wr_data  in   instruction word to store
//   len      in   number of instructions to issue, sampled on start
//   start    in   begin issuing from address 0
//   abort    in   stop issuing and return to IDLE (wins over start)
//   iin      out  registered instruction word, 0 whenever valid=0
//   valid    out  iin holds a program instruction
//   pc       out  address of the instruction currently on iin
//   busy     out  state is RUN
//   done     out  last run completed; sticky until start/abort/reset
// ----------------------------------------------------------------------------
module instruction_feeder #(
    parameter int DEPTH = 16,
    parameter int DWELL = 4
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [15:0]              wr_data,
    input  logic [$clog2(DEPTH):0]   len,
    input  logic                     start,
    input  logic                     abort,
    output logic [15:0]              iin,
    output logic                     valid,
    output logic [$clog2(DEPTH)-1:0] pc,
    output logic                     busy,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [AW:0]   DEPTH_L    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEN_ONE    = (AW+1)'(1);
    localparam logic [AW:0]   LEN_ZERO   = (AW+1)'(0);
    localparam logic [AW-1:0] PC_ONE     = AW'(1);
    localparam logic [AW-1:0] PC_ZERO    = AW'(0);
    localparam logic [3:0]    DWELL_LAST = 4'(DWELL - 1);

    logic [15:0]   mem_r [DEPTH];

    logic [1:0]    state_r,  state_s;
    logic [AW:0]   len_r,    len_s;
    logic [AW-1:0] pc_r,     pc_s;
    logic [3:0]    dwell_r,  dwell_s;
    logic [15:0]   iin_r,    iin_s;
    logic          valid_r,  valid_s;
    logic          busy_r,   busy_s;
    logic          done_r,   done_s;

    logic          wr_ok_s;
    logic [15:0]   mem0_s;
    logic [15:0]   mem_next_s;
    logic [AW-1:0] pc_inc_s;
    logic [AW:0]   len_sat_s;
    logic          last_s;
    logic          dwell_end_s;

    // Writes are locked out while a program is being issued.
    assign wr_ok_s     = wr_en && (state_r != ST_RUN);
    // A write to word 0 in the start cycle must be seen by the first issue.
    assign mem0_s      = (wr_ok_s && (wr_addr == PC_ZERO)) ? wr_data : mem_r[0];
    assign pc_inc_s    = pc_r + PC_ONE;
    // No bypass needed here: memory cannot change during RUN.
    assign mem_next_s  = mem_r[pc_inc_s];
    // Saturating len to DEPTH guarantees pc stops at DEPTH-1 and never wraps.
    assign len_sat_s   = (len > DEPTH_L) ? DEPTH_L : len;
    assign last_s      = ({1'b0, pc_r} == (len_r - LEN_ONE));
    assign dwell_end_s = (dwell_r == DWELL_LAST);

    // Next-state and next-output computation for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_s = state_r;
        len_s   = len_r;
        pc_s    = pc_r;
        dwell_s = dwell_r;
        iin_s   = iin_r;
        valid_s = valid_r;
        busy_s  = busy_r;
        done_s  = done_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (abort) begin
                    state_s = ST_IDLE;
                    pc_s    = PC_ZERO;
                    dwell_s = 4'd0;
                    iin_s   = 16'h0000;
                    valid_s = 1'b0;
                    busy_s  = 1'b0;
                    done_s  = 1'b0;
                end else if (start) begin
                    pc_s    = PC_ZERO;
                    dwell_s = 4'd0;
                    if (len == LEN_ZERO) begin
                        // Empty program: finish immediately, nothing issued.
                        state_s = ST_DONE;
                        iin_s   = 16'h0000;
                        valid_s = 1'b0;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_RUN;
                        len_s   = len_sat_s;
                        iin_s   = mem0_s;
                        valid_s = 1'b1;
                        busy_s  = 1'b1;
                        done_s  = 1'b0;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_s = ST_IDLE;
                    pc_s    = PC_ZERO;
                    dwell_s = 4'd0;
                    iin_s   = 16'h0000;
                    valid_s = 1'b0;
                    busy_s  = 1'b0;
                    done_s  = 1'b0;
                end else if (dwell_end_s) begin
                    dwell_s = 4'd0;
                    if (last_s) begin
                        // pc keeps the last issued address for visibility.
                        state_s = ST_DONE;
                        iin_s   = 16'h0000;
                        valid_s = 1'b0;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                    end else begin
                        pc_s  = pc_inc_s;
                        iin_s = mem_next_s;
                    end
                end else begin
                    dwell_s = dwell_r + 4'd1;
                end
            end
            default: begin
                // Unreachable encoding: recover to a quiet IDLE.
                state_s = ST_IDLE;
                len_s   = LEN_ZERO;
                pc_s    = PC_ZERO;
                dwell_s = 4'd0;
                iin_s   = 16'h0000;
                valid_s = 1'b0;
                busy_s  = 1'b0;
                done_s  = 1'b0;
            end
        endcase
    end

    // Sequencer and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            len_r   <= LEN_ZERO;
            pc_r    <= PC_ZERO;
            dwell_r <= 4'd0;
            iin_r   <= 16'h0000;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            len_r   <= len_s;
            pc_r    <= pc_s;
            dwell_r <= dwell_s;
            iin_r   <= iin_s;
            valid_r <= valid_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Program memory: not cleared by reset, but reset blocks a same-cycle write.
    always_ff @(posedge clock) begin
        if (resetn && wr_ok_s) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign iin   = iin_r;
    assign valid = valid_r;
    assign pc    = pc_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule
